// File: rtl/lsu_store_buffer_pkg.sv
// lsu_store_buffer_pkg: shared sizes and slot/memory-write record types for the store buffer
package lsu_store_buffer_pkg;
  localparam int SB_ENTRY    = 8;
  localparam int WORD_SIZE_P = 16;
  localparam int SB_PTR_W    = $clog2(SB_ENTRY);
  localparam int SB_CNT_W    = SB_PTR_W + 1;
  typedef struct packed {
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
    logic                   rdy;
  } sb_entry_t;
  typedef struct packed {
    logic                   v;
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
  } sb_mem_wr_t;
endpackage

// File: rtl/sb_bypass_match.sv
// sb_bypass_match: age-masked address compare with youngest-older-store priority select
// Ports:
//   i_slots  all slot records (addr, data, rdy)
//   i_head   oldest occupied slot
//   i_sb_num first slot younger than the load (scan stops before it)
//   i_addr   load address
//   o_hit    some older resolved store matches i_addr
//   o_value  data of the youngest such store, 0 when no hit
module sb_bypass_match
  import lsu_store_buffer_pkg::*;
(
  input  sb_entry_t [SB_ENTRY-1:0] i_slots,
  input  logic [SB_PTR_W-1:0]      i_head,
  input  logic [SB_PTR_W-1:0]      i_sb_num,
  input  logic [WORD_SIZE_P-1:0]   i_addr,
  output logic                     o_hit,
  output logic [WORD_SIZE_P-1:0]   o_value
);
  logic [SB_PTR_W-1:0] w_lim;
  assign w_lim = i_sb_num - i_head;
  // walk in age order from head; later (younger) matches override earlier ones
  always_comb begin
    o_hit   = 1'b0;
    o_value = '0;
    for (int k = 0; k < SB_ENTRY; k++) begin
      if (SB_PTR_W'(k) < w_lim && i_slots[i_head + SB_PTR_W'(k)].rdy &&
          i_slots[i_head + SB_PTR_W'(k)].addr == i_addr) begin
        o_hit   = 1'b1;
        o_value = i_slots[i_head + SB_PTR_W'(k)].data;
      end
    end
  end
endmodule

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: in-order store buffer, allocate at dispatch, drain to memory after commit
// Optional feature: define SB_LD_BYPASS_EN to enable store-to-load forwarding.
// Ports:
//   clk_i, reset_ni                          clock, async active-low reset
//   alloc_v_i / alloc_ready_o / alloc_idx_o  slot allocation at dispatch
//   lsu_sb_v_i, lsu_sb_dest_i/addr_i/data_i  store address/data writeback
//   ld_bypass_addr_i, ld_bypass_sb_num_i     load lookup; ld_bypass_valid_o/value_o result
//   commit_v_i, mispredict_i                 ROB retire / flush of uncommitted slots
//   mem_w_v_o/addr_o/data_o, mem_w_ready_i   memory write port
module lsu_store_buffer
  import lsu_store_buffer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   alloc_v_i,
  output logic                   alloc_ready_o,
  output logic [SB_PTR_W-1:0]    alloc_idx_o,
  input  logic                   lsu_sb_v_i,
  input  logic [SB_PTR_W-1:0]    lsu_sb_dest_i,
  input  logic [WORD_SIZE_P-1:0] lsu_sb_addr_i,
  input  logic [WORD_SIZE_P-1:0] lsu_sb_data_i,
  input  logic [WORD_SIZE_P-1:0] ld_bypass_addr_i,
  input  logic [SB_PTR_W-1:0]    ld_bypass_sb_num_i,
  output logic                   ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0] ld_bypass_value_o,
  input  logic                   commit_v_i,
  input  logic                   mispredict_i,
  output logic                   mem_w_v_o,
  output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_w_data_o,
  input  logic                   mem_w_ready_i
);
  sb_entry_t [SB_ENTRY-1:0] r_sb;
  logic [SB_PTR_W-1:0] r_head, r_cmt, r_tail;
  // r_count: occupied slots (head..tail), r_ncmt: committed, not yet drained (head..cmt)
  logic [SB_CNT_W-1:0] r_count, r_ncmt, w_count_nxt, w_ncmt_nxt;
  logic w_alloc, w_commit, w_drain, w_wb;
  sb_mem_wr_t w_mem;
  assign alloc_ready_o = !r_count[SB_PTR_W];
  assign alloc_idx_o   = r_tail;
  assign w_alloc  = alloc_v_i && alloc_ready_o && !mispredict_i;
  assign w_commit = commit_v_i && (r_ncmt != r_count);
  // only slots inside head..tail accept a writeback
  assign w_wb = lsu_sb_v_i && !mispredict_i && ({1'b0, lsu_sb_dest_i - r_head} < r_count);
  // ncmt rather than head!=cmt so a fully committed ring still drains
  assign w_mem.v    = (r_ncmt != '0) && r_sb[r_head].rdy;
  assign w_mem.addr = w_mem.v ? r_sb[r_head].addr : '0;
  assign w_mem.data = w_mem.v ? r_sb[r_head].data : '0;
  assign w_drain    = w_mem.v && mem_w_ready_i;
  assign mem_w_v_o    = w_mem.v;
  assign mem_w_addr_o = w_mem.addr;
  assign mem_w_data_o = w_mem.data;
  assign w_ncmt_nxt  = r_ncmt + SB_CNT_W'(w_commit) - SB_CNT_W'(w_drain);
  // on flush tail snaps to the (possibly just advanced) cmt, so occupancy equals committed count
  assign w_count_nxt = mispredict_i ? w_ncmt_nxt : r_count + SB_CNT_W'(w_alloc) - SB_CNT_W'(w_drain);
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sb    <= '0;
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ncmt  <= '0;
    end else begin
      r_head  <= r_head + SB_PTR_W'(w_drain);
      r_cmt   <= r_cmt + SB_PTR_W'(w_commit);
      r_tail  <= mispredict_i ? r_cmt + SB_PTR_W'(w_commit) : r_tail + SB_PTR_W'(w_alloc);
      r_count <= w_count_nxt;
      r_ncmt  <= w_ncmt_nxt;
      if (w_wb) r_sb[lsu_sb_dest_i] <= '{addr: lsu_sb_addr_i, data: lsu_sb_data_i, rdy: 1'b1};
      if (w_drain) r_sb[r_head].rdy <= 1'b0;
      if (w_alloc) r_sb[r_tail].rdy <= 1'b0;
    end
  end
`ifdef SB_LD_BYPASS_EN
  sb_bypass_match u_bypass (
    .i_slots  (r_sb),
    .i_head   (r_head),
    .i_sb_num (ld_bypass_sb_num_i),
    .i_addr   (ld_bypass_addr_i),
    .o_hit    (ld_bypass_valid_o),
    .o_value  (ld_bypass_value_o)
  );
`else
  logic w_unused_bypass;
  assign w_unused_bypass   = ^{ld_bypass_addr_i, ld_bypass_sb_num_i};
  assign ld_bypass_valid_o = 1'b0;
  assign ld_bypass_value_o = '0;
`endif
  a_commit_pending: assert property (@(posedge clk_i) disable iff (!reset_ni)
    commit_v_i |-> (r_ncmt != r_count));
endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb_lsu_store_buffer: directed self-checking bench for lsu_store_buffer
module tb_lsu_store_buffer;
  logic        clk_i = 1'b0, reset_ni = 1'b0;
  logic        alloc_v_i, alloc_ready_o, lsu_sb_v_i, commit_v_i, mispredict_i, mem_w_ready_i;
  logic [2:0]  alloc_idx_o, lsu_sb_dest_i, ld_bypass_sb_num_i;
  logic [15:0] lsu_sb_addr_i, lsu_sb_data_i, ld_bypass_addr_i, ld_bypass_value_o;
  logic        ld_bypass_valid_o, mem_w_v_o;
  logic [15:0] mem_w_addr_o, mem_w_data_o;
  int errors = 0, checks = 0;
`ifdef SB_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  lsu_store_buffer dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .lsu_sb_v_i(lsu_sb_v_i), .lsu_sb_dest_i(lsu_sb_dest_i),
    .lsu_sb_addr_i(lsu_sb_addr_i), .lsu_sb_data_i(lsu_sb_data_i),
    .ld_bypass_addr_i(ld_bypass_addr_i), .ld_bypass_sb_num_i(ld_bypass_sb_num_i),
    .ld_bypass_valid_o(ld_bypass_valid_o), .ld_bypass_value_o(ld_bypass_value_o),
    .commit_v_i(commit_v_i), .mispredict_i(mispredict_i),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_w_ready_i(mem_w_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    {alloc_v_i, lsu_sb_v_i, commit_v_i, mispredict_i, mem_w_ready_i} = '0;
    lsu_sb_dest_i = '0; lsu_sb_addr_i = '0; lsu_sb_data_i = '0;
    ld_bypass_addr_i = '0; ld_bypass_sb_num_i = '0;
    tick();
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic alloc_n(input int n);
    alloc_v_i = 1'b1;
    repeat (n) tick();
    alloc_v_i = 1'b0;
  endtask

  task automatic wb(input logic [2:0] dest, input logic [15:0] a, input logic [15:0] d);
    lsu_sb_v_i = 1'b1; lsu_sb_dest_i = dest; lsu_sb_addr_i = a; lsu_sb_data_i = d;
    tick();
    lsu_sb_v_i = 1'b0;
  endtask

  task automatic commit_n(input int n);
    commit_v_i = 1'b1;
    repeat (n) tick();
    commit_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    {alloc_v_i, lsu_sb_v_i, commit_v_i, mispredict_i, mem_w_ready_i} = '0;
    ld_bypass_addr_i = '0; ld_bypass_sb_num_i = '0;
    tick();
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b1_000) begin
      errors++; $display("FAIL reset_alloc: ready/idx=%b/%0d expected 1/0", alloc_ready_o, alloc_idx_o);
    end
    checks++;
    if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== 33'd0) begin
      errors++; $display("FAIL reset_mem: v=%b a=%h d=%h expected all 0", mem_w_v_o, mem_w_addr_o, mem_w_data_o);
    end
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== 17'd0) begin
      errors++; $display("FAIL reset_bypass: v=%b val=%h expected 0/0", ld_bypass_valid_o, ld_bypass_value_o);
    end
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic_drain();
    do_reset();
    alloc_n(3);
    checks++;
    if (alloc_idx_o !== 3'd3) begin
      errors++; $display("FAIL basic_alloc_idx: got %0d expected 3", alloc_idx_o);
    end
    wb(3'd0, 16'h0010, 16'hBEEF);
    checks++;
    if (mem_w_v_o !== 1'b0) begin
      errors++; $display("FAIL basic_uncommitted: mem_w_v_o=%b expected 0", mem_w_v_o);
    end
    commit_n(1);
    checks++;
    if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== {1'b1, 16'h0010, 16'hBEEF}) begin
      errors++; $display("FAIL basic_write: v=%b a=%h d=%h expected 1/0010/beef", mem_w_v_o, mem_w_addr_o, mem_w_data_o);
    end
    mem_w_ready_i = 1'b1;
    tick();
    mem_w_ready_i = 1'b0;
    checks++;
    if (mem_w_v_o !== 1'b0) begin
      errors++; $display("FAIL basic_drained: mem_w_v_o=%b expected 0", mem_w_v_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(8);
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b0_000) begin
      errors++; $display("FAIL full_ready: ready/idx=%b/%0d expected 0/0", alloc_ready_o, alloc_idx_o);
    end
    alloc_n(1);
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b0_000) begin
      errors++; $display("FAIL full_ignored: ready/idx=%b/%0d expected 0/0", alloc_ready_o, alloc_idx_o);
    end
    wb(3'd0, 16'h0100, 16'h5555);
    commit_n(1);
    alloc_v_i = 1'b1;
    mem_w_ready_i = 1'b1;
    checks++;
    if ({alloc_ready_o, mem_w_v_o} !== 2'b01) begin
      errors++; $display("FAIL full_drain_cycle: ready/v=%b%b expected 0/1", alloc_ready_o, mem_w_v_o);
    end
    tick();
    alloc_v_i = 1'b0;
    mem_w_ready_i = 1'b0;
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b1_000) begin
      errors++; $display("FAIL full_after_drain: ready/idx=%b/%0d expected 1/0", alloc_ready_o, alloc_idx_o);
    end
    alloc_n(1);
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b0_001) begin
      errors++; $display("FAIL full_realloc: ready/idx=%b/%0d expected 0/1", alloc_ready_o, alloc_idx_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(4);
    wb(3'd0, 16'h0050, 16'h3333);
    wb(3'd1, 16'h0040, 16'h1111);
    wb(3'd2, 16'h0040, 16'h2222);
    ld_bypass_addr_i = 16'h0040; ld_bypass_sb_num_i = 3'd3; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== (BYP ? {1'b1, 16'h2222} : 17'd0)) begin
      errors++; $display("FAIL bypass_num3: v/val=%b/%h expected %b/%h", ld_bypass_valid_o, ld_bypass_value_o, BYP, BYP ? 16'h2222 : 16'h0);
    end
    ld_bypass_sb_num_i = 3'd2; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== (BYP ? {1'b1, 16'h1111} : 17'd0)) begin
      errors++; $display("FAIL bypass_num2: v/val=%b/%h expected %b/%h", ld_bypass_valid_o, ld_bypass_value_o, BYP, BYP ? 16'h1111 : 16'h0);
    end
    ld_bypass_sb_num_i = 3'd1; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== 17'd0) begin
      errors++; $display("FAIL bypass_num1: v/val=%b/%h expected 0/0000", ld_bypass_valid_o, ld_bypass_value_o);
    end
    ld_bypass_addr_i = 16'h0050; ld_bypass_sb_num_i = 3'd3; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== (BYP ? {1'b1, 16'h3333} : 17'd0)) begin
      errors++; $display("FAIL bypass_other_addr: v/val=%b/%h expected %b/%h", ld_bypass_valid_o, ld_bypass_value_o, BYP, BYP ? 16'h3333 : 16'h0);
    end
    ld_bypass_addr_i = 16'h0040; ld_bypass_sb_num_i = 3'd4;
    lsu_sb_v_i = 1'b1; lsu_sb_dest_i = 3'd3; lsu_sb_addr_i = 16'h0040; lsu_sb_data_i = 16'h4444; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== (BYP ? {1'b1, 16'h2222} : 17'd0)) begin
      errors++; $display("FAIL bypass_same_cycle_wb: v/val=%b/%h expected %b/%h", ld_bypass_valid_o, ld_bypass_value_o, BYP, BYP ? 16'h2222 : 16'h0);
    end
    tick();
    lsu_sb_v_i = 1'b0; #1;
    checks++;
    if ({ld_bypass_valid_o, ld_bypass_value_o} !== (BYP ? {1'b1, 16'h4444} : 17'd0)) begin
      errors++; $display("FAIL bypass_after_wb: v/val=%b/%h expected %b/%h", ld_bypass_valid_o, ld_bypass_value_o, BYP, BYP ? 16'h4444 : 16'h0);
    end
    ld_bypass_addr_i = '0; ld_bypass_sb_num_i = '0;
  endtask

  task automatic test_mispredict();
    int nw;
    logic [15:0] seen [2];
    do_reset();
    alloc_n(5);
    for (int i = 0; i < 5; i++) wb(3'(i), 16'h0200 + 16'(i), 16'hA000 + 16'(i));
    commit_n(2);
    mispredict_i = 1'b1; alloc_v_i = 1'b1;
    tick();
    mispredict_i = 1'b0; alloc_v_i = 1'b0;
    checks++;
    if ({alloc_ready_o, alloc_idx_o} !== 4'b1_010) begin
      errors++; $display("FAIL mispredict_tail: ready/idx=%b/%0d expected 1/2", alloc_ready_o, alloc_idx_o);
    end
    nw = 0;
    seen[0] = '0; seen[1] = '0;
    mem_w_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (mem_w_v_o) begin
        if (nw < 2) seen[nw] = mem_w_addr_o;
        nw++;
      end
      tick();
    end
    mem_w_ready_i = 1'b0;
    checks++;
    if (nw !== 2) begin
      errors++; $display("FAIL mispredict_writes: got %0d writes expected 2", nw);
    end
    checks++;
    if ({seen[0], seen[1]} !== {16'h0200, 16'h0201}) begin
      errors++; $display("FAIL mispredict_order: addrs %h,%h expected 0200,0201", seen[0], seen[1]);
    end
    checks++;
    if (alloc_idx_o !== 3'd2) begin
      errors++; $display("FAIL mispredict_idx_hold: got %0d expected 2", alloc_idx_o);
    end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    mem_w_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      alloc_n(1);
      wb(3'(i), 16'h0300 + 16'(i), 16'h0);
      commit_n(1);
      tick();
    end
    mem_w_ready_i = 1'b0;
    checks++;
    if ({mem_w_v_o, alloc_idx_o} !== 4'b0_111) begin
      errors++; $display("FAIL wrap_setup: v/idx=%b/%0d expected 0/7", mem_w_v_o, alloc_idx_o);
    end
    alloc_n(2);
    wb(3'd7, 16'h0777, 16'h7777);
    wb(3'd0, 16'h0800, 16'h8888);
    commit_n(2);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== {1'b1, 16'h0777, 16'h7777}) begin
        errors++; $display("FAIL stall_hold[%0d]: v=%b a=%h d=%h expected 1/0777/7777", c, mem_w_v_o, mem_w_addr_o, mem_w_data_o);
      end
      tick();
    end
    mem_w_ready_i = 1'b1;
    tick();
    checks++;
    if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== {1'b1, 16'h0800, 16'h8888}) begin
      errors++; $display("FAIL wrap_slot0: v=%b a=%h d=%h expected 1/0800/8888", mem_w_v_o, mem_w_addr_o, mem_w_data_o);
    end
    tick();
    mem_w_ready_i = 1'b0;
    checks++;
    if (mem_w_v_o !== 1'b0) begin
      errors++; $display("FAIL wrap_empty: mem_w_v_o=%b expected 0", mem_w_v_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    alloc_n(1);
    wb(3'd0, 16'h0123, 16'h4567);
    commit_n(1);
    checks++;
    if ({mem_w_v_o, mem_w_addr_o} !== {1'b1, 16'h0123}) begin
      errors++; $display("FAIL middrain_pre: v=%b a=%h expected 1/0123", mem_w_v_o, mem_w_addr_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o, alloc_ready_o, alloc_idx_o} !== {33'd0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL middrain_async: v=%b a=%h d=%h ready=%b idx=%0d expected 0/0/0/1/0",
                         mem_w_v_o, mem_w_addr_o, mem_w_data_o, alloc_ready_o, alloc_idx_o);
    end
    tick();
    reset_ni = 1'b1;
    mem_w_ready_i = 1'b1;
    tick();
    mem_w_ready_i = 1'b0;
    checks++;
    if (mem_w_v_o !== 1'b0) begin
      errors++; $display("FAIL middrain_abandoned: mem_w_v_o=%b expected 0", mem_w_v_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_full();
    test_bypass();
    test_mispredict();
    test_stall_wrap();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
